gauss_pulse_shaper: RTL and testbench

GAUSS_PULSE_SHAPER -- requirements
Module: gauss_pulse_shaper

---
 rtl/gauss_pkg.sv | 26 ++
 rtl/gauss_sat.sv | 56 +++++
 rtl/gauss_pulse_shaper.sv | 180 ++++++++++++++++++
 tb/tb_gauss_pulse_shaper.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_pkg.sv
// Shared types and constants for the Gaussian pulse shaper: FSM states,
// delay-line level type and the default BT=0.5 tap set.
package gauss_pkg;

  localparam int MAX_TAPS = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef logic signed [1:0] level_t;

  localparam level_t LVL_ZERO = 2'sb00;
  localparam level_t LVL_POS  = 2'sb01;
  localparam level_t LVL_NEG  = 2'sb11;

  // BT=0.5 Gaussian taps, tap 0 in the LSBs; the taps sum to 100.
  localparam logic [39:0] GAUSS_BT05_COEF = {8'd4, 8'd20, 8'd52, 8'd20, 8'd4};

  function automatic level_t sym_to_level(input logic bit_val);
    return bit_val ? LVL_POS : LVL_NEG;
  endfunction

endpackage

// File: rtl/gauss_sat.sv
// Output stage of the pulse shaper: arithmetic right shift by SHIFT, clamp to
// the signed OUT_W range, then register the sample together with its valid.
module gauss_sat
  import gauss_pkg::*;
#(
  parameter int IN_W  = 13,
  parameter int OUT_W = 12,
  parameter int SHIFT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vld_i,
  input  logic signed [IN_W-1:0] din_i,
  output logic                   vld_o,
  output logic [OUT_W-1:0]       dout_o
);

  // One guard bit above the wider operand keeps both clamp limits representable.
  localparam int W = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;
  localparam logic signed [W-1:0] MAX_V = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = {{(W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] shifted;
  logic signed [W-1:0]    wide;
  logic [OUT_W-1:0]       dout_d;
  logic [OUT_W-1:0]       dout_q;
  logic                   vld_q;

  assign shifted = din_i >>> SHIFT;
  assign wide    = {{(W-IN_W){shifted[IN_W-1]}}, shifted};

  always_comb begin
    dout_d = wide[OUT_W-1:0];
    if (wide > MAX_V) begin
      dout_d = MAX_V[OUT_W-1:0];
    end else if (wide < MIN_V) begin
      dout_d = MIN_V[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      vld_q <= vld_i;
      if (vld_i) begin
        dout_q <= dout_d;
      end
    end
  end

  assign vld_o  = vld_q;
  assign dout_o = dout_q;

endmodule

// File: rtl/gauss_pulse_shaper.sv
// Gaussian pulse shaper: maps symbol bits to +/-1 levels, filters them through
// an NTAPS FIR and scales/saturates. Macro GAUSS_COEF_LOAD_EN makes taps writable.
module gauss_pulse_shaper
  import gauss_pkg::*;
#(
  parameter int                      NTAPS     = 5,
  parameter int                      COEF_W    = 8,
  parameter int                      OUT_W     = 12,
  parameter int                      SHIFT     = 0,
  parameter logic [NTAPS*COEF_W-1:0] COEF_INIT = GAUSS_BT05_COEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sym_valid,
  input  logic              sym_data,
  output logic              sym_ready,
  input  logic              flush_req,
  input  logic              coef_we,
  input  logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              busy
);

  localparam int ACC_W = COEF_W + $clog2(NTAPS) + 2;
  localparam int CNT_W = $clog2(MAX_TAPS);
  localparam logic [CNT_W-1:0] LAST_INJ = CNT_W'(NTAPS - 2);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_FLUSH = ST_FLUSH;

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  level_t                  line_q [NTAPS];
  level_t                  line_d [NTAPS];
  logic [COEF_W-1:0]       coef [NTAPS];
  logic                    accept;
  logic                    shift;
  level_t                  new_level;
  logic                    shift_q;
  logic signed [ACC_W-1:0] sum_d, sum_q;
  logic                    sum_vld_q;

  assign sym_ready = ~rst & (state_q != S_FLUSH);
  assign busy      = (state_q == S_RUN) | (state_q == S_FLUSH);
  assign accept    = sym_valid & sym_ready;
  assign shift     = accept | (state_q == S_FLUSH);
  assign new_level = accept ? sym_to_level(sym_data) : LVL_ZERO;

  // A flush request in RUN still lets a coincident symbol in; draining starts next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (flush_req) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end
      end
      S_FLUSH: begin
        if (cnt_q == LAST_INJ) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    line_d = line_q;
    if (shift) begin
      line_d[0] = new_level;
      for (int k = 1; k < NTAPS; k++) begin
        line_d[k] = line_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        line_q[k] <= LVL_ZERO;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift;
      line_q  <= line_d;
    end
  end

`ifdef GAUSS_COEF_LOAD_EN
  logic [COEF_W-1:0] coef_q [NTAPS];

  // Addresses at or above NTAPS match no tap and are silently dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) begin
        coef_q[k] <= COEF_INIT[k*COEF_W +: COEF_W];
      end
    end else if (coef_we) begin
      for (int k = 0; k < NTAPS; k++) begin
        if (coef_addr == 4'(k)) begin
          coef_q[k] <= coef_data;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NTAPS; k++) begin
      coef[k] = coef_q[k];
    end
  end
`else
  logic unused_coef;
  assign unused_coef = ^{coef_we, coef_addr, coef_data};

  always_comb begin
    for (int k = 0; k < NTAPS; k++) begin
      coef[k] = COEF_INIT[k*COEF_W +: COEF_W];
    end
  end
`endif

  // Levels are only -1/0/+1, so each product reduces to add, subtract or skip.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NTAPS; k++) begin
      case (line_q[k])
        LVL_POS: sum_d = sum_d + ACC_W'(coef[k]);
        LVL_NEG: sum_d = sum_d - ACC_W'(coef[k]);
        default: sum_d = sum_d;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_vld_q <= 1'b0;
      sum_q     <= '0;
    end else begin
      sum_vld_q <= shift_q;
      if (shift_q) begin
        sum_q <= sum_d;
      end
    end
  end

  gauss_sat #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_sat (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (sum_vld_q),
    .din_i  (sum_q),
    .vld_o  (out_valid),
    .dout_o (out_data)
  );

endmodule

// File: tb/tb_gauss_pulse_shaper.sv
// Bench for gauss_pulse_shaper: directed scenarios plus a randomized run against
// a tap-history reference model; expectations follow GAUSS_COEF_LOAD_EN.
module tb_gauss_pulse_shaper;

  localparam int NTAPS   = 5;
  localparam int COEF_W  = 8;
  localparam int OUT_W   = 12;
  localparam int OUT_W_S = 6;

  logic clk = 1'b0;
  logic rst;
  logic sym_valid, sym_data, flush_req, coef_we;
  logic [3:0] coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic sym_ready, out_valid, busy;
  logic [OUT_W-1:0] out_data;
  logic symReadyS, outValidS, busyS;
  logic [OUT_W_S-1:0] outDataS;

  always #5 clk = ~clk;

  gauss_pulse_shaper #(.NTAPS(NTAPS), .COEF_W(COEF_W), .OUT_W(OUT_W), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .flush_req(flush_req), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_data(out_data), .busy(busy)
  );

  gauss_pulse_shaper #(.NTAPS(NTAPS), .COEF_W(COEF_W), .OUT_W(OUT_W_S), .SHIFT(0)) dutSat (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(symReadyS),
    .flush_req(flush_req), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(outValidS), .out_data(outDataS), .busy(busyS)
  );

  typedef struct {
    int due;
    int wide;
    int narrow;
  } sample_t;

  int initCoef[NTAPS] = '{4, 20, 52, 20, 4};
  int exp039[6] = '{-100, -92, -52, 52, 92, 100};
  int exp040[5] = '{4, 20, 52, 20, 4};
  int coefM[NTAPS];
  int histM[NTAPS];
  int modeM;
  int zerosLeft;
  int cyc;
  sample_t expQ[$];
  int seenQ[$];
  int seenSQ[$];
  logic [OUT_W-1:0] lastData;
  logic [OUT_W_S-1:0] lastDataS;
  int vecCount = 0;
  int errCount = 0;
  int lowCnt;
  int finalExp;

  function automatic int clampTo(input int v, input int bits);
    int hi;
    int lo;
    hi = (1 << (bits - 1)) - 1;
    lo = -(1 << (bits - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < NTAPS; k++) begin
      coefM[k] = initCoef[k];
      histM[k] = 0;
    end
    modeM = 0;
    zerosLeft = 0;
    expQ.delete();
    lastData = '0;
    lastDataS = '0;
  endfunction

  task automatic checkOutput(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    vecCount++;
    assert (obs === expv) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // One clock edge: advance the model from the inputs held across the edge, then compare.
  task automatic stepCycle();
    logic acc;
    logic doShift;
    int lvl;
    int sum;
    sample_t s;
    @(posedge clk);
    #1;
    cyc++;
    acc = sym_valid && (modeM != 2);
    doShift = acc || (modeM == 2);
    lvl = acc ? (sym_data ? 1 : -1) : 0;
`ifdef GAUSS_COEF_LOAD_EN
    if (coef_we && coef_addr < NTAPS) coefM[coef_addr] = int'(coef_data);
`endif
    case (modeM)
      0: if (acc) modeM = 1;
      1: if (flush_req) begin
           modeM = 2;
           zerosLeft = NTAPS - 1;
         end
      default: begin
        zerosLeft--;
        if (zerosLeft == 0) modeM = 0;
      end
    endcase
    if (expQ.size() > 0 && expQ[0].due == cyc) begin
      s = expQ.pop_front();
      checkOutput("out_valid", out_valid, 1);
      checkOutput("out_data", $signed(out_data), s.wide);
      checkOutput("sat out_valid", outValidS, 1);
      checkOutput("sat out_data", $signed(outDataS), s.narrow);
      lastData = OUT_W'(s.wide);
      lastDataS = OUT_W_S'(s.narrow);
      seenQ.push_back(int'($signed(out_data)));
      seenSQ.push_back(int'($signed(outDataS)));
    end else begin
      checkOutput("out_valid quiet", out_valid, 0);
      checkOutput("out_data hold", $signed(out_data), $signed(lastData));
      checkOutput("sat out_valid quiet", outValidS, 0);
      checkOutput("sat out_data hold", $signed(outDataS), $signed(lastDataS));
    end
    if (doShift) begin
      for (int k = NTAPS - 1; k > 0; k--) histM[k] = histM[k-1];
      histM[0] = lvl;
      sum = 0;
      for (int k = 0; k < NTAPS; k++) sum += histM[k] * coefM[k];
      s.due = cyc + 2;
      s.wide = clampTo(sum, OUT_W);
      s.narrow = clampTo(sum, OUT_W_S);
      expQ.push_back(s);
    end
    checkOutput("busy", busy, modeM != 0);
    checkOutput("sym_ready", sym_ready, modeM != 2);
    checkOutput("sat busy", busyS, modeM != 0);
    checkOutput("sat sym_ready", symReadyS, modeM != 2);
  endtask

  task automatic applyStimulus(input logic v, input logic d, input logic f);
    sym_valid = v;
    sym_data = d;
    flush_req = f;
    stepCycle();
  endtask

  task automatic applyReset(input int cycles);
    sym_valid = 1'b0;
    flush_req = 1'b0;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rst out_valid", out_valid, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst sym_ready", sym_ready, 0);
    checkOutput("rst out_data", $signed(out_data), 0);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post-rst sym_ready", sym_ready, 1);
    checkOutput("post-rst busy", busy, 0);
  endtask

  task automatic drain();
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (NTAPS + 2) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    sym_valid = 1'b0;
    sym_data = 1'b0;
    flush_req = 1'b0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    rst = 1'b0;
    cyc = 0;
    modelReset();
    #2;
    applyReset(2);

    // Five +1 symbols back to back: five pulses, last one the full tap sum.
    seenQ.delete();
    seenSQ.delete();
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ones count", seenQ.size(), 5);
    checkOutput("ones fifth", seenQ[4], 100);
    checkOutput("ones sat fifth", seenSQ[4], 31);
    drain();
    checkOutput("ones idle busy", busy, 0);

    // Five -1 then five +1 symbols.
    seenQ.delete();
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("step count", seenQ.size(), 10);
    for (int i = 0; i < 6; i++) checkOutput($sformatf("step sample %0d", i), seenQ[4 + i], exp039[i]);
    drain();

    // Single +1 from IDLE then flush: impulse response appears in order.
    applyReset(1);
    seenQ.delete();
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    lowCnt = sym_ready ? 0 : 1;
    repeat (6) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      lowCnt += sym_ready ? 0 : 1;
    end
    checkOutput("impulse count", seenQ.size(), 5);
    for (int i = 0; i < 5; i++) checkOutput($sformatf("impulse sample %0d", i), seenQ[i], exp040[i]);
    checkOutput("ready low cycles", lowCnt, 4);
    checkOutput("impulse idle busy", busy, 0);

    // Coefficient writes, including out-of-range addresses.
    applyReset(1);
    coef_we = 1'b1;
    coef_addr = 4'd2;
    coef_data = 8'd60;
    applyStimulus(1'b0, 1'b0, 1'b0);
    coef_addr = 4'd7;
    coef_data = 8'd200;
    applyStimulus(1'b0, 1'b0, 1'b0);
    coef_addr = 4'd10;
    applyStimulus(1'b0, 1'b0, 1'b0);
    coef_we = 1'b0;
    seenQ.delete();
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
`ifdef GAUSS_COEF_LOAD_EN
    finalExp = 108;
`else
    finalExp = 100;
`endif
    checkOutput("coef write final", seenQ[4], finalExp);
    drain();

    // Reset in the middle of a flush with samples still in the pipeline.
    applyReset(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyReset(2);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      coef_we = ($urandom_range(0, 19) == 0);
      coef_addr = 4'($urandom_range(0, 15));
      coef_data = 8'($urandom_range(0, 255));
      if (i == 200) applyReset(1);
      applyStimulus($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
    end
    coef_we = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
